ysyx_22041461_lsu: RTL and testbench

Multi-cycle load/store unit that sits between the execute stage and the data-memory bus. It is the first step in replacing the zero-latency data-memory access in the single-cycle core with a handshaked one. Per operation it: accepts one request; checks natural alignment; builds the 8-byte-aligned bus beat (write mask and shifted data); waits for the bus; then returns a sign- or zero-extended load result or a store-done response. One operation is in flight at a time.

---
 rtl/ysyx_22041461_lsu_pkg.sv | 24 ++
 rtl/ysyx_22041461_lsu_align.sv | 58 +++++
 rtl/ysyx_22041461_lsu.sv | 138 +++++++++++++
 tb/tb_ysyx_22041461_lsu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041461_lsu_pkg.sv
// Shared constants and types for the load/store unit.
//   - size codes carried on req_size
//   - LSU state encodings
//   - bus beat width
package ysyx_22041461_lsu_pkg;

   localparam int XLEN   = 64;
   localparam int BEAT_W = 64;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_RESP = 2'b11
   } lsu_state_e;

endpackage

// File: rtl/ysyx_22041461_lsu_align.sv
// Combinational lane logic for the LSU.
//   size/is_unsigned/offset : access descriptor (offset = addr[2:0])
//   wdata      -> wdata_lane : store data moved to its byte lane
//   rdata      -> rdata_ext  : load field extracted and sign/zero extended
//   misalign                 : access not naturally aligned
//   wmask                    : byte-lane enables for the beat
module ysyx_22041461_lsu_align
   import ysyx_22041461_lsu_pkg::*;
(
   input  size_e              size,
   input  logic               is_unsigned,
   input  logic [2:0]         offset,
   input  logic [XLEN-1:0]    wdata,
   input  logic [BEAT_W-1:0]  rdata,
   output logic               misalign,
   output logic [7:0]         wmask,
   output logic [BEAT_W-1:0]  wdata_lane,
   output logic [XLEN-1:0]    rdata_ext
);

   logic [5:0]        bit_shift;
   logic [BEAT_W-1:0] rdata_sh;

   assign bit_shift  = {offset, 3'b000};
   assign wdata_lane = wdata << bit_shift;
   assign rdata_sh   = rdata >> bit_shift;

   always_comb begin
      misalign  = 1'b0;
      wmask     = 8'h00;
      rdata_ext = '0;
      case (size)
         SZ_B: begin
            wmask     = 8'h01 << offset;
            rdata_ext = is_unsigned ? {56'b0, rdata_sh[7:0]}
                                    : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
         end
         SZ_H: begin
            misalign  = offset[0];
            wmask     = 8'h03 << offset;
            rdata_ext = is_unsigned ? {48'b0, rdata_sh[15:0]}
                                    : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
         end
         SZ_W: begin
            misalign  = |offset[1:0];
            wmask     = 8'h0F << offset;
            rdata_ext = is_unsigned ? {32'b0, rdata_sh[31:0]}
                                    : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
         end
         default: begin
            misalign  = |offset;
            wmask     = 8'hFF;
            rdata_ext = rdata_sh;
         end
      endcase
   end

endmodule

// File: rtl/ysyx_22041461_lsu.sv
// Multi-cycle load/store unit between execute and the data-memory bus.
// One operation in flight; request fields are captured on accept.
//   req_*  : request from execute (req_ready high only in IDLE)
//   mem_*  : handshaked bus beat (8-byte aligned address, lane mask/data)
//   resp_* : registered one-cycle completion, zero when resp_valid is low
//
// state   | meaning
// IDLE    | ready for a new request
// REQ     | bus beat presented, waiting for mem_ready
// WAIT    | load issued, waiting for mem_rvalid
// RESP    | one-cycle completion pulse
module ysyx_22041461_lsu
   import ysyx_22041461_lsu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [4:0]        req_rd,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [XLEN-1:0]   mem_addr,
   output logic              mem_wen,
   output logic [BEAT_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic              mem_rvalid,
   input  logic [BEAT_W-1:0] mem_rdata,
   output logic              resp_valid,
   output logic              resp_wen,
   output logic [4:0]        resp_rd,
   output logic [XLEN-1:0]   resp_data,
   output logic              resp_err
);

   lsu_state_e        state, state_nxt;

   logic              wen_q, uns_q;
   size_e             size_q;
   logic [XLEN-1:0]   addr_q, wdata_q;
   logic [4:0]        rd_q;

   logic              accept, load_done;
   logic              in_idle, in_req, store_beat;
   size_e             al_size;
   logic              al_uns;
   logic [2:0]        al_offset;
   logic              misalign;
   logic [7:0]        wmask;
   logic [BEAT_W-1:0] wdata_lane;
   logic [XLEN-1:0]   rdata_ext;

   assign in_idle    = (state == ST_IDLE);
   assign in_req     = (state == ST_REQ);
   assign accept     = in_idle && req_valid;
   assign load_done  = (state == ST_WAIT) && mem_rvalid;
   assign store_beat = in_req && wen_q;

   // Alignment is judged on the live request in IDLE; afterwards the
   // captured fields drive lane mask/data and load extraction.
   assign al_size   = in_idle ? size_e'(req_size) : size_q;
   assign al_uns    = in_idle ? req_unsigned : uns_q;
   assign al_offset = in_idle ? req_addr[2:0] : addr_q[2:0];

   ysyx_22041461_lsu_align u_align (
      .size        (al_size),
      .is_unsigned (al_uns),
      .offset      (al_offset),
      .wdata       (wdata_q),
      .rdata       (mem_rdata),
      .misalign    (misalign),
      .wmask       (wmask),
      .wdata_lane  (wdata_lane),
      .rdata_ext   (rdata_ext)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_valid)  state_nxt = misalign ? ST_RESP : ST_REQ;
         ST_REQ:  if (mem_ready)  state_nxt = wen_q ? ST_RESP : ST_WAIT;
         ST_WAIT: if (mem_rvalid) state_nxt = ST_RESP;
         default:                 state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         wen_q   <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= SZ_B;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            wen_q   <= req_wen;
            uns_q   <= req_unsigned;
            size_q  <= size_e'(req_size);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
         end
      end
   end

   // Response registers load only on entry to RESP, so they read zero
   // in every other cycle. A load without error reaches RESP only via WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_wen   <= 1'b0;
         resp_rd    <= '0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= (state_nxt == ST_RESP);
         resp_wen   <= load_done;
         resp_rd    <= (state_nxt != ST_RESP) ? 5'd0 : (in_idle ? req_rd : rd_q);
         resp_data  <= load_done ? rdata_ext : '0;
         resp_err   <= accept && misalign;
      end
   end

   assign req_ready = in_idle;
   assign mem_valid = in_req;
   assign mem_addr  = in_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
   assign mem_wen   = store_beat;
   assign mem_wdata = store_beat ? wdata_lane : '0;
   assign mem_wmask = store_beat ? wmask : 8'h00;

endmodule

// File: tb/tb_ysyx_22041461_lsu.sv
module tb_ysyx_22041461_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen, req_unsigned;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;
   logic        resp_valid, resp_wen, resp_err;
   logic [4:0]  resp_rd;
   logic [63:0] resp_data;

   always #5 clk = ~clk;

   ysyx_22041461_lsu dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wen      (req_wen),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_addr     (mem_addr),
      .mem_wen      (mem_wen),
      .mem_wdata    (mem_wdata),
      .mem_wmask    (mem_wmask),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .resp_valid   (resp_valid),
      .resp_wen     (resp_wen),
      .resp_rd      (resp_rd),
      .resp_data    (resp_data),
      .resp_err     (resp_err)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // results of the last do_op
   int          lat, pulses;
   logic [63:0] r_data, m_addr, m_wdata;
   logic [7:0]  m_wmask;
   logic [4:0]  r_rd;
   logic        r_wen, r_err, m_seen, m_stable, rdy_after, quiet;

   // Issue one request (accept edge = cycle 0) and act as the bus:
   // mem_ready after rdy_dly stall cycles, mem_rvalid after rv_dly more.
   task automatic do_op(input logic wen, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [4:0] rd, input logic [63:0] rdata,
                        input int rdy_dly, input int rv_dly);
      int   rdy_cnt = 0;
      int   rv_cnt  = 0;
      logic wait_ph = 1'b0;
      lat = -1; pulses = 0; m_seen = 0; m_stable = 1; rdy_after = 0; quiet = 1;
      r_data = '0; r_wen = 0; r_err = 0; r_rd = '0;
      m_addr = '0; m_wdata = '0; m_wmask = '0;
      req_valid = 1; req_wen = wen; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_rd = rd; mem_rdata = rdata;
      step();
      req_valid = 0;
      for (int cyc = 1; cyc <= 25; cyc++) begin
         mem_ready  = 0;
         mem_rvalid = 0;
         if (lat >= 0 && cyc == lat + 1) rdy_after = req_ready;
         if (mem_valid) begin
            if (!m_seen) begin
               m_seen = 1; m_addr = mem_addr; m_wdata = mem_wdata; m_wmask = mem_wmask;
            end else if (mem_addr !== m_addr || mem_wdata !== m_wdata || mem_wmask !== m_wmask)
               m_stable = 0;
            if (rdy_cnt == rdy_dly) begin
               mem_ready = 1;
               if (!wen) wait_ph = 1;
            end
            rdy_cnt++;
         end else if (wait_ph) begin
            if (rv_cnt == rv_dly) begin
               mem_rvalid = 1;
               wait_ph = 0;
            end
            rv_cnt++;
         end
         if (resp_valid) begin
            if (pulses == 0) begin
               lat = cyc; r_data = resp_data; r_wen = resp_wen; r_err = resp_err; r_rd = resp_rd;
            end
            pulses++;
         end else if (resp_data !== 64'd0 || resp_wen !== 1'b0 || resp_err !== 1'b0)
            quiet = 0;
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      logic seen_resp;
      rst = 1; req_valid = 0; req_wen = 0; req_size = 0; req_unsigned = 0;
      req_addr = '0; req_wdata = '0; req_rd = '0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
      step(); step();
      chk("rst_req_ready",  req_ready,  1);
      chk("rst_mem_valid",  mem_valid,  0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data",  resp_data,  0);
      chk("rst_mem_addr",   mem_addr,   0);
      rst = 0;
      step();

      // store byte at lane 3
      do_op(1, 2'b00, 0, 64'h8000_0003, 64'hAB, 5'd0, 64'h0, 0, 0);
      chk("sb_mem_addr",  m_addr,  64'h8000_0000);
      chk("sb_wmask",     m_wmask, 8'h08);
      chk("sb_wdata",     m_wdata, 64'h0000_0000_AB00_0000);
      chk("sb_lat",       lat,     2);
      chk("sb_resp_wen",  r_wen,   0);
      chk("sb_resp_data", r_data,  0);
      chk("sb_pulses",    pulses,  1);
      chk("sb_ready_nxt", rdy_after, 1);

      // load half signed from lane 6
      do_op(0, 2'b01, 0, 64'h8000_0006, 64'h0, 5'd5, 64'h8001_0000_0000_0000, 0, 0);
      chk("lh_data",    r_data,  64'hFFFF_FFFF_FFFF_8001);
      chk("lh_rd",      r_rd,    5'd5);
      chk("lh_lat",     lat,     3);
      chk("lh_wen",     r_wen,   1);
      chk("lh_wmask",   m_wmask, 8'h00);
      chk("lh_addr",    m_addr,  64'h8000_0000);
      chk("lh_quiet",   quiet,   1);

      // load word unsigned from lane 4
      do_op(0, 2'b10, 1, 64'h8000_0004, 64'h0, 5'd9, 64'hF000_0000_1234_5678, 0, 0);
      chk("lwu_data", r_data, 64'h0000_0000_F000_0000);
      chk("lwu_rd",   r_rd,   5'd9);

      // load byte signed / unsigned from lane 1
      do_op(0, 2'b00, 0, 64'h8000_0011, 64'h0, 5'd3, 64'h0000_0000_0000_8000, 0, 0);
      chk("lb_data",  r_data, 64'hFFFF_FFFF_FFFF_FF80);
      do_op(0, 2'b00, 1, 64'h8000_0011, 64'h0, 5'd3, 64'h0000_0000_0000_8000, 0, 0);
      chk("lbu_data", r_data, 64'h0000_0000_0000_0080);

      // store word at lane 4, store dword
      do_op(1, 2'b10, 0, 64'h8000_0024, 64'h5566_7788_1122_3344, 5'd0, 64'h0, 0, 0);
      chk("sw_wmask", m_wmask, 8'hF0);
      chk("sw_wdata", m_wdata, 64'h1122_3344_0000_0000);
      chk("sw_addr",  m_addr,  64'h8000_0020);
      do_op(1, 2'b11, 0, 64'h8000_0028, 64'h0123_4567_89AB_CDEF, 5'd0, 64'h0, 0, 0);
      chk("sd_wmask", m_wmask, 8'hFF);
      chk("sd_wdata", m_wdata, 64'h0123_4567_89AB_CDEF);

      // misaligned word load
      do_op(0, 2'b10, 0, 64'h8000_0002, 64'h0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
      chk("mis_err",    r_err,  1);
      chk("mis_lat",    lat,    1);
      chk("mis_wen",    r_wen,  0);
      chk("mis_data",   r_data, 0);
      chk("mis_no_mem", m_seen, 0);
      // misaligned half store
      do_op(1, 2'b01, 0, 64'h8000_0005, 64'h1234, 5'd0, 64'h0, 0, 0);
      chk("mis_sh_err",    r_err,  1);
      chk("mis_sh_no_mem", m_seen, 0);

      // stalled dword load: 4 cycles ready stall, 3 cycles rvalid delay
      do_op(0, 2'b11, 1, 64'h8000_0008, 64'h0, 5'd12, 64'h0123_4567_89AB_CDEF, 4, 3);
      chk("stall_lat",    lat,      10);
      chk("stall_stable", m_stable, 1);
      chk("stall_pulses", pulses,   1);
      chk("stall_data",   r_data,   64'h0123_4567_89AB_CDEF);
      chk("stall_addr",   m_addr,   64'h8000_0008);

      // reset while in WAIT
      req_valid = 1; req_wen = 0; req_size = 2'b11; req_unsigned = 0;
      req_addr = 64'h8000_0010; req_rd = 5'd4; mem_rdata = 64'hDEAD_BEEF_0000_0001;
      step();
      req_valid = 0;
      mem_ready = 1;
      step();
      mem_ready = 0;
      chk("wait_no_mem", mem_valid, 0);
      chk("wait_busy",   req_ready, 0);
      rst = 1;
      #1;
      chk("wrst_req_ready",  req_ready,  1);
      chk("wrst_resp_valid", resp_valid, 0);
      rst = 0;
      mem_rvalid = 1;
      step();
      mem_rvalid = 0;
      seen_resp = 0;
      for (int i = 0; i < 4; i++) begin
         if (resp_valid) seen_resp = 1;
         step();
      end
      chk("wrst_no_resp", seen_resp, 0);

      // reset while in REQ drops mem_valid without an edge
      req_valid = 1; req_wen = 1; req_size = 2'b11; req_addr = 64'h8000_0030;
      step();
      req_valid = 0;
      chk("rrst_mem_valid_pre", mem_valid, 1);
      rst = 1;
      #1;
      chk("rrst_mem_valid", mem_valid, 0);
      chk("rrst_mem_wmask", mem_wmask, 0);
      rst = 0;
      step();

      // normal operation after reset
      do_op(0, 2'b10, 0, 64'h8000_0040, 64'h0, 5'd31, 64'h0000_0000_8000_0000, 0, 0);
      chk("post_data", r_data, 64'hFFFF_FFFF_8000_0000);
      chk("post_lat",  lat,    3);
      chk("post_rd",   r_rd,   5'd31);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
